// File: rtl/serial_instr_rx.sv
// Bit-serial instruction receiver: one bit per 4-phase data_ready/data_ack handshake,
// words delivered on a valid/accept handshake with backpressure and an abort timeout.
//
// state  | meaning
// IDLE   | waiting for synced data_ready (bit_cnt>0 means a frame is in progress)
// SAMPLE | capture synced data bit into shift reg or parity flop
// ACK    | data_ack high, waiting for synced data_ready to drop
// DONE   | word presented, data_ready ignored until accepted
// RESYNC | after an abort, wait for data_ready low before listening again
module serial_instr_rx #(
  parameter int WIDTH       = 10,
  parameter int MSB_FIRST   = 1,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_ready,
  input  logic             data_bit,
  output logic             data_ack,
  output logic [WIDTH-1:0] instruction,
  output logic             instr_valid,
  input  logic             instr_accept,
  output logic             parity_err,
  output logic             timeout_err,
  output logic [2:0]       state
);

  localparam bit PAR_EN   = (PARITY_EN != 0);
  localparam bit PAR_ODD  = (PARITY_ODD != 0);
  localparam bit TIMER_EN = (TIMEOUT > 0);
  localparam int FRAME    = WIDTH + (PAR_EN ? 1 : 0);
  localparam int CW       = $clog2(FRAME + 1);
  localparam int TW       = TIMER_EN ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] CNT_WIDTH  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_FRAME  = CW'(FRAME);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMER_EN ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_ACK    = 3'd2,
    S_DONE   = 3'd3,
    S_RESYNC = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] rdy_sync_q, rdy_sync_d;
  logic [SYNC_STAGES-1:0] bit_sync_q, bit_sync_d;
  logic [WIDTH-1:0]       sh_q, sh_d;
  logic [WIDTH-1:0]       instr_q, instr_d;
  logic                   par_q, par_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   tout_q, tout_d;
  logic                   rdy_s, bit_s;
  logic                   timer_run, abort;

  // Both inputs share one synchroniser depth so a bit stays aligned with its strobe.
  always_comb begin
    rdy_sync_d = {rdy_sync_q[SYNC_STAGES-2:0], data_ready};
    bit_sync_d = {bit_sync_q[SYNC_STAGES-2:0], data_bit};
  end

  assign rdy_s = rdy_sync_q[SYNC_STAGES-1];
  assign bit_s = bit_sync_q[SYNC_STAGES-1];

  assign timer_run = TIMER_EN &&
                     ((state_q == S_ACK) || ((state_q == S_IDLE) && (bit_cnt_q != '0)));
  assign abort     = timer_run && (timer_q == TIMER_LAST);

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    instr_d   = instr_q;
    perr_d    = perr_q;
    tout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rdy_s) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (PAR_EN && (bit_cnt_q == CNT_WIDTH)) begin
          par_d = bit_s;
        end else if (MSB_FIRST != 0) begin
          sh_d = {sh_q[WIDTH-2:0], bit_s};
        end else begin
          sh_d = {bit_s, sh_q[WIDTH-1:1]};
        end
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!rdy_s) begin
          if (bit_cnt_q == CNT_FRAME) begin
            instr_d = sh_q;
            perr_d  = PAR_EN & (^sh_q ^ par_q ^ PAR_ODD);
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (instr_accept) begin
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      S_RESYNC: begin
        if (!rdy_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled handshake or abandoned frame wins over any normal transition.
    if (abort) begin
      sh_d      = '0;
      bit_cnt_d = '0;
      tout_d    = 1'b1;
      state_d   = S_RESYNC;
    end

    ack_d   = (state_d == S_ACK);
    valid_d = (state_d == S_DONE);
    timer_d = (timer_run && (state_d == state_q)) ? timer_q + TW'(1) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rdy_sync_q <= '0;
      bit_sync_q <= '0;
      sh_q       <= '0;
      instr_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_sync_q <= rdy_sync_d;
      bit_sync_q <= bit_sync_d;
      sh_q       <= sh_d;
      instr_q    <= instr_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      tout_q     <= tout_d;
    end
  end

  assign data_ack    = ack_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign parity_err  = perr_q;
  assign timeout_err = tout_q;
  assign state       = state_q;

endmodule
